tg_lock_ctrl: RTL



---
 rtl/tg_lock_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/tg_lock_ctrl.sv
// tg_lock_ctrl -- frame-lock controller for the 720p output timing generator.
//
// Compares received-stream frame starts against the generator's vertical
// position, pulses the generator's vertical clear to pull it into phase,
// tracks lock quality and flags loss of the incoming signal.
//
// Ports:
//   clk74m          in   pixel clock, sole clock
//   restart         in   synchronous active-high reset
//   enable          in   level; 0 holds the block in IDLE
//   rx_frame_start  in   one-cycle pulse at received-frame wrap (already in clk74m)
//   tg_hcount[10:0] in   generator horizontal count
//   tg_vcount[10:0] in   generator vertical count
//   tg_vclr         out  one-cycle pulse to the generator's vertical clear
//   locked          out  high while in LOCKED
//   no_signal       out  frame-start timeout flag
//   state[1:0]      out  0 IDLE, 1 ACQUIRE, 2 TRACK, 3 LOCKED
//   phase_err[11:0] out  signed error sampled at the last evaluated frame start
//   resync_cnt[7:0] out  number of vclr pulses issued, saturating at 255
//
// Every output is registered: all responses to an input sampled at an edge
// become visible in the cycle after that edge.

module tg_lock_ctrl #(
    parameter int VTOTAL         = 749,
    parameter int TOL            = 2,
    parameter int LOCK_CNT       = 4,
    parameter int LOSS_CNT       = 3,
    parameter int TIMEOUT_FRAMES = 3
) (
    input  logic        clk74m,
    input  logic        restart,
    input  logic        enable,
    input  logic        rx_frame_start,
    input  logic [10:0] tg_hcount,
    input  logic [10:0] tg_vcount,
    output logic        tg_vclr,
    output logic        locked,
    output logic        no_signal,
    output logic [1:0]  state,
    output logic [11:0] phase_err,
    output logic [7:0]  resync_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_CNT + 1);
    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);

    localparam logic [MW-1:0] LOCK_V    = MW'(LOCK_CNT);
    localparam logic [LW-1:0] LOSS_V    = LW'(LOSS_CNT);
    localparam logic [TW-1:0] TMO_V     = TW'(TIMEOUT_FRAMES);
    localparam logic [11:0]   HALF_V    = 12'(VTOTAL / 2);
    localparam logic [11:0]   LINES_V   = 12'(VTOTAL + 1);
    localparam logic [11:0]   TOL_V     = 12'(TOL);

    state_t          state_reg, state_next;
    logic            vclr_reg, vclr_next;
    logic            locked_reg, locked_next;
    logic            no_signal_reg, no_signal_next;
    logic [11:0]     phase_err_reg, phase_err_next;
    logic [7:0]      resync_cnt_reg, resync_cnt_next;
    logic [MW-1:0]   match_cnt_reg, match_cnt_next;
    logic [LW-1:0]   miss_cnt_reg, miss_cnt_next;
    logic [TW-1:0]   tmo_cnt_reg, tmo_cnt_next;

    logic [11:0]     vcount_ext;
    logic [11:0]     err;
    logic [11:0]     err_abs;
    logic            is_match;
    logic            wrap;
    logic            do_vclr;

    // Signed phase error: lines past the generator's frame start are positive,
    // lines before the wrap (upper half of the frame) are negative.
    assign vcount_ext = {1'b0, tg_vcount};
    assign err        = (vcount_ext <= HALF_V) ? vcount_ext : (vcount_ext - LINES_V);
    assign err_abs    = err[11] ? (~err + 12'd1) : err;
    assign is_match   = (err_abs <= TOL_V);
    assign wrap       = (tg_vcount == 11'd0) && (tg_hcount == 11'd0);

    always_comb begin
        state_next      = state_reg;
        vclr_next       = 1'b0;
        no_signal_next  = no_signal_reg;
        phase_err_next  = phase_err_reg;
        resync_cnt_next = resync_cnt_reg;
        match_cnt_next  = match_cnt_reg;
        miss_cnt_next   = miss_cnt_reg;
        tmo_cnt_next    = tmo_cnt_reg;
        do_vclr         = 1'b0;

        if (state_reg == IDLE) begin
            if (enable) begin
                state_next = ACQUIRE;
            end
        end else if (!enable) begin
            state_next     = IDLE;
            no_signal_next = 1'b0;
            match_cnt_next = '0;
            miss_cnt_next  = '0;
            tmo_cnt_next   = '0;
        end else if (rx_frame_start) begin
            // A frame start always beats a coincident generator wrap.
            tmo_cnt_next   = '0;
            no_signal_next = 1'b0;
            case (state_reg)
                ACQUIRE: begin
                    do_vclr        = 1'b1;
                    match_cnt_next = '0;
                    state_next     = TRACK;
                end
                TRACK: begin
                    phase_err_next = err;
                    if (is_match) begin
                        match_cnt_next = match_cnt_reg + 1'b1;
                        if (match_cnt_reg + 1'b1 == LOCK_V) begin
                            state_next    = LOCKED;
                            miss_cnt_next = '0;
                        end
                    end else begin
                        do_vclr        = 1'b1;
                        match_cnt_next = '0;
                    end
                end
                LOCKED: begin
                    phase_err_next = err;
                    if (is_match) begin
                        miss_cnt_next = '0;
                    end else if (miss_cnt_reg + 1'b1 == LOSS_V) begin
                        do_vclr        = 1'b1;
                        match_cnt_next = '0;
                        miss_cnt_next  = '0;
                        state_next     = TRACK;
                    end else begin
                        miss_cnt_next = miss_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end else if (wrap) begin
            if (tmo_cnt_reg + 1'b1 == TMO_V) begin
                no_signal_next = 1'b1;
                state_next     = ACQUIRE;
                match_cnt_next = '0;
                miss_cnt_next  = '0;
                tmo_cnt_next   = '0;
            end else begin
                tmo_cnt_next = tmo_cnt_reg + 1'b1;
            end
        end

        if (do_vclr) begin
            vclr_next = 1'b1;
            if (resync_cnt_reg != 8'hFF) begin
                resync_cnt_next = resync_cnt_reg + 8'd1;
            end
        end

        // locked is a registered decode of the next state so it moves with it.
        locked_next = (state_next == LOCKED);
    end

    always_ff @(posedge clk74m) begin
        if (restart) begin
            state_reg      <= IDLE;
            vclr_reg       <= 1'b0;
            locked_reg     <= 1'b0;
            no_signal_reg  <= 1'b0;
            phase_err_reg  <= '0;
            resync_cnt_reg <= '0;
            match_cnt_reg  <= '0;
            miss_cnt_reg   <= '0;
            tmo_cnt_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            vclr_reg       <= vclr_next;
            locked_reg     <= locked_next;
            no_signal_reg  <= no_signal_next;
            phase_err_reg  <= phase_err_next;
            resync_cnt_reg <= resync_cnt_next;
            match_cnt_reg  <= match_cnt_next;
            miss_cnt_reg   <= miss_cnt_next;
            tmo_cnt_reg    <= tmo_cnt_next;
        end
    end

    assign tg_vclr    = vclr_reg;
    assign locked     = locked_reg;
    assign no_signal  = no_signal_reg;
    assign state      = state_reg;
    assign phase_err  = phase_err_reg;
    assign resync_cnt = resync_cnt_reg;

endmodule
